// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and grant/index conversion helpers for the memory arbiter path.
package mem_arb_pkg;
    localparam int N_REQ     = 10;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 4;
    localparam int IDX_W     = $clog2(N_REQ);

    // OR-reduces the indices of set bits; multi flags more than one bit set.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh, output logic multi);
        logic [IDX_W-1:0] idx;
        logic seen;
        idx = '0;
        seen = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                multi = multi | seen;
                seen = 1'b1;
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction
endpackage

// File: rtl/mem_grant_router_if.sv
// mem_grant_router_if: requester-side grant/command bus plus memory command/read-return bus.
interface mem_grant_router_if #(
    parameter int N  = 10,
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [N-1:0]    grant;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            ready;
    logic [N-1:0]    ack;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            err;

    modport slave (
        input  grant, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        output ready, ack, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, err
    );
    modport master (
        output grant, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        input  ready, ack, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, err
    );
endinterface

// File: rtl/mem_grant_router_tag_fifo.sv
// tag_fifo: synchronous FIFO of requester indices for reads awaiting in-order return data.
module tag_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full = cnt_q[PW];
        empty = cnt_q == '0;
        count = cnt_q;
        dout = mem_q[rd_q];
        do_push = push & ~full;
        do_pop = pop & ~empty;
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_grant_router.sv
// mem_grant_router: registers the granted requester's command onto the memory port and
// routes in-order read data back to the originating requester as a one-hot response.
module mem_grant_router
    import mem_arb_pkg::*;
#(
    parameter int N     = N_REQ,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W,
    parameter int DEPTH = TAG_DEPTH
) (
    input logic               clk,
    input logic               rst,
    mem_grant_router_if.slave bus
);
    logic [IDX_W-1:0]      k, tag;
    logic                  multi, accept, push, pop, full, empty;
    logic [$clog2(DEPTH):0] count;
    logic                  mem_en_d, mem_en_q, mem_we_d, mem_we_q, err_d, err_q;
    logic [AW-1:0]         mem_addr_d, mem_addr_q;
    logic [DW-1:0]         mem_wdata_d, mem_wdata_q, rsp_data_d, rsp_data_q;
    logic [N-1:0]          rsp_valid_d, rsp_valid_q;

    tag_fifo #(.W(IDX_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(k), .dout(tag),
        .full(full), .empty(empty), .count(count)
    );

    always_comb begin
        k = onehot2idx(bus.grant, multi);
        // No bypass: a pop in the same cycle never frees a slot for a new accept.
        bus.ready = ~rst & ~full;
        bus.ack = multi ? '0 : bus.grant & {N{bus.ready}};
        accept = |bus.grant & bus.ready & ~multi;
        push = accept & ~bus.req_we[k];
        pop = bus.mem_rvalid & (count != '0);
        mem_en_d = accept;
        mem_we_d = accept ? bus.req_we[k] : mem_we_q;
        mem_addr_d = accept ? bus.req_addr[k*AW +: AW] : mem_addr_q;
        mem_wdata_d = accept ? bus.req_wdata[k*DW +: DW] : mem_wdata_q;
        rsp_valid_d = pop ? idx2onehot(tag) : '0;
        rsp_data_d = pop ? bus.mem_rdata : rsp_data_q;
        err_d = err_q | multi | (bus.mem_rvalid & empty);
        bus.mem_en = mem_en_q;
        bus.mem_we = mem_we_q;
        bus.mem_addr = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data = rsp_data_q;
        bus.err = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q <= '0;
            err_q <= 1'b0;
        end else begin
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_grant_router.sv
// tb_mem_grant_router: cycle model of accept/tag/response behaviour with a response scoreboard.
module tb_mem_grant_router;
    localparam int N = 10, AW = 16, DW = 32, DEPTH = 4;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_grant_router_if #(.N(N), .AW(AW), .DW(DW)) bus ();
    mem_grant_router #(.N(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    rsp_t          exp_q[$];
    int            tag_q[$];
    logic          m_en, m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [AW-1:0] addr_a[N];
    logic [DW-1:0] wd_a[N];
    int            n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'($urandom);
            wd_a[i] = $urandom;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        tag_q.delete();
        m_en = 0; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        bus.grant = 10'h004;
        bus.mem_rvalid = 1'b0;
        #1;
        check("rst_ready", bus.ready, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_err", bus.err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] g, input logic [N-1:0] we, input logic rv, input logic [DW-1:0] rd);
        int k;
        bit multi, rdy, acc;
        rsp_t r;
        bus.grant = g;
        bus.req_we = we;
        bus.mem_rvalid = rv;
        bus.mem_rdata = rd;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = addr_a[i];
            bus.req_wdata[i*DW +: DW] = wd_a[i];
        end
        #1;
        multi = $countones(g) > 1;
        rdy = tag_q.size() < DEPTH;
        acc = (g != 0) && !multi && rdy;
        check("ready", bus.ready, rdy);
        check("ack", bus.ack, acc ? g : '0);
        k = 0;
        for (int i = 0; i < N; i++) if (g[i]) k = i;
        m_en = acc;
        if (acc) begin
            m_we = we[k];
            m_addr = addr_a[k];
            m_wdata = wd_a[k];
        end
        m_err = m_err | multi | (rv && tag_q.size() == 0);
        if (rv && tag_q.size() != 0) begin
            int t = tag_q.pop_front();
            r.vld = N'(1) << t;
            r.data = rd;
            exp_q.push_back(r);
            m_rdata = rd;
        end
        if (acc && !we[k]) tag_q.push_back(k);
        @(posedge clk);
        #1;
        check("mem_en", bus.mem_en, m_en);
        check("mem_we", bus.mem_we, m_we);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("err", bus.err, m_err);
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, r.vld);
            check("rsp_data", bus.rsp_data, r.data);
        end else begin
            check("rsp_idle", bus.rsp_valid, 0);
            check("rsp_hold", bus.rsp_data, m_rdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, $urandom);
    endtask

    initial begin
        bus.grant = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        randomize_reqs();
        apply_reset();
        addr_a[2] = 16'h0010;
        wd_a[2] = 32'hDEADBEEF;
        step(10'h004, 10'h004, 1'b0, '0);
        idle(3);
        randomize_reqs();
        step(10'h001, '0, 1'b0, '0);
        step(10'h200, '0, 1'b0, '0);
        step(10'h008, '0, 1'b1, 32'h11);
        idle(2);
        step('0, '0, 1'b1, 32'h22);
        idle(2);
        step('0, '0, 1'b1, 32'h33);
        idle(2);
        step(10'h002, '0, 1'b0, '0);
        step(10'h020, '0, 1'b0, '0);
        step(10'h080, 10'h001, 1'b0, '0);
        step(10'h100, '0, 1'b0, '0);
        step(10'h010, '0, 1'b0, '0);
        step(10'h040, '0, 1'b0, '0);
        step(10'h010, '0, 1'b1, 32'hAA);
        step(10'h010, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, $urandom);
        idle(1);
        for (int c = 0; c < 80; c++) begin
            logic [N-1:0] g;
            randomize_reqs();
            g = ($urandom_range(0, 3) == 0) ? '0 : (N'(1) << $urandom_range(0, N-1));
            step(g, N'($urandom), (tag_q.size() != 0) && ($urandom_range(0, 1) == 1), $urandom);
        end
        while (tag_q.size() != 0) step('0, '0, 1'b1, $urandom);
        step(10'h005, '0, 1'b0, '0);
        idle(3);
        apply_reset();
        idle(1);
        step('0, '0, 1'b1, 32'h55);
        idle(2);
        apply_reset();
        step(10'h001, '0, 1'b0, '0);
        step(10'h200, '0, 1'b0, '0);
        apply_reset();
        idle(1);
        step('0, '0, 1'b1, 32'h77);
        idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_grant_router.md
# mem_grant_router

Bank-side consumer of the one-hot grant produced by the fixed-priority request arbiter in the memory subsystem. Each cycle it takes the winning requester's command, registers it onto a single-ported memory interface, and records the winner's index for reads. Read data returning in order from memory is routed back to the originating requester as a one-hot response. It closes the request/grant loop: requesters see an accept pulse, then (for reads) a tagged response.

## Interface

- N, 10, number of requesters; must match the arbiter width
- AW, 16, address width
- DW, 32, data width
- DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- grant  in  N  one-hot (or zero) grant from the arbiter
- req_we  in  N  per-requester write enable
- req_addr  in  N*AW  per-requester address, requester i at bits [i*AW +: AW]
- req_wdata  in  N*DW  per-requester write data, same packing
- ready  out  1  router can accept a command this cycle
- ack  out  N  one-hot accept pulse to the winning requester
- mem_en  out  1  memory command valid, registered
- mem_we  out  1  memory write, registered
- mem_addr  out  AW  registered
- mem_wdata  out  DW  registered
- mem_rvalid  in  1  read data valid; memory returns reads in issue order, latency ≥1
- mem_rdata  in  DW  read data
- rsp_valid  out  N  one-hot read response strobe, registered
- rsp_data  out  DW  read response data, registered
- err  out  1  sticky protocol error flag

## Operation

- Winner index: k = index of the set bit of grant. accept = |grant & ready.
- ready = ~rst & (count < DEPTH). There is no bypass: a full FIFO blocks accepts even if a pop occurs in the same cycle. Writes are blocked too, which keeps ordering simple.
- ack = grant & {N{ready}} (combinational). The requester drops its request on ack.
- On accept, the command fields register into the mem_* outputs: mem_en=1, mem_we=req_we[k], mem_addr=req_addr[k], mem_wdata=req_wdata[k]. With no accept, mem_en=0 and the other mem_* outputs hold their values.
- On accepting a read (req_we[k]=0), push k into the tag FIFO. Writes push nothing and receive no response.
- On mem_rvalid with a non-empty FIFO: pop the tag t, then register rsp_valid = 1<<t and rsp_data = mem_rdata. Otherwise rsp_valid = 0 and rsp_data holds.
- Push and pop in the same cycle: count is unchanged and the FIFO order is preserved.
- err is set, and stays set until rst, when either of these occurs:
  - grant has more than one bit set. The command is not accepted: ack=0, no push.
  - mem_rvalid arrives with the FIFO empty. The data is dropped.

## Timing

- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, err=0, FIFO empty (count=0).
- ready=0 and ack=0 while rst is asserted.
- Accept in cycle t gives mem_en=1 in cycle t+1. Back-to-back accepts give back-to-back mem_en.
- mem_rvalid in cycle r gives rsp_valid in cycle r+1, lasting exactly one cycle per beat.
- Asserting rst mid-operation discards all outstanding tags. Any memory read data returning after reset sets err.
- Wrap-around: the read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Structure

- Package mem_arb_pkg holds:
  - IDX_W = $clog2(N)
  - the function onehot2idx (one-hot to binary, with a multi-hot detect output)
  - the function idx2onehot
- Sub-module tag_fifo: synchronous FIFO, width IDX_W, depth DEPTH, with push/pop/full/empty/count ports. It shares clk and rst.
- The router top holds the command register, response register, error logic and ready/ack generation.

## Test plan

- Single write: grant=0x004, req_we[2]=1, addr 0x0010, wdata 0xDEADBEEF.
  - Same cycle: ack=0x004.
  - Next cycle: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF.
  - No rsp_valid ever.
- Interleaved reads: reads from requesters 0, 9, 3; memory returns 0x11, 0x22, 0x33 with rvalid latencies 1, 3, 3.
  - Required: rsp_valid = 0x001, 0x200, 0x008 in order, with the matching data, each one cycle after its rvalid.
- Full FIFO: issue 4 reads with no rvalid.
  - Then: ready=0, and a 5th grant gets ack=0 and mem_en=0.
  - One rvalid: count drops to 3 and ready=1 the next cycle. A same-cycle push is refused.
- Multi-hot grant=0x005: ack=0, mem_en=0 the next cycle, err=1 and it stays high.
- Spurious rvalid with the FIFO empty: err=1, rsp_valid stays 0.
- Reset mid-flight: 2 reads outstanding, pulse rst.
  - All outputs return to reset values, ready=1 after rst deasserts.
  - A later rvalid sets err.
